// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between the data-side cache (port 0)
// and the instruction-fetch miss path (port 1); latches the granted request while busy.
module sram_port_arbiter #(
    parameter int ADDR_LEN  = 32,
    parameter int DATA_LEN  = 32,
    parameter int BLOCK_LEN = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p0_read_en,
    input  logic                 p0_write_en,
    input  logic [ADDR_LEN-1:0]  p0_address,
    input  logic [DATA_LEN-1:0]  p0_write_data,
    output logic [BLOCK_LEN-1:0] p0_read_data,
    output logic                 p0_ready,
    input  logic                 p1_read_en,
    input  logic                 p1_write_en,
    input  logic [ADDR_LEN-1:0]  p1_address,
    input  logic [DATA_LEN-1:0]  p1_write_data,
    output logic [BLOCK_LEN-1:0] p1_read_data,
    output logic                 p1_ready,
    output logic                 sram_read_en,
    output logic                 sram_write_en,
    output logic [ADDR_LEN-1:0]  sram_address,
    output logic [DATA_LEN-1:0]  sram_write_data,
    input  logic [BLOCK_LEN-1:0] sram_read_data,
    input  logic                 sram_ready,
    output logic [1:0]           grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic [ADDR_LEN-1:0]    op_addr_q, op_addr_d;
    logic [DATA_LEN-1:0]    op_wdata_q, op_wdata_d;
    logic                   op_is_read_q, op_is_read_d;
    logic [BLOCK_LEN-1:0]   p0_rdata_q, p0_rdata_d;
    logic [BLOCK_LEN-1:0]   p1_rdata_q, p1_rdata_d;

    logic p0_req_s;
    logic p1_req_s;
    logic pick_p1_s;
    logic p0_done_s;
    logic p1_done_s;

    assign p0_req_s  = p0_read_en | p0_write_en;
    assign p1_req_s  = p1_read_en | p1_write_en;
    // On a tie the port that did not own the previous transaction wins.
    assign pick_p1_s = (p0_req_s & p1_req_s) ? ~last_grant_q : p1_req_s;
    assign p0_done_s = (state_q == BUSY0) & sram_ready;
    assign p1_done_s = (state_q == BUSY1) & sram_ready;

    // State and latched-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_addr_q    <= {ADDR_LEN{1'b0}};
            op_wdata_q   <= {DATA_LEN{1'b0}};
            op_is_read_q <= 1'b0;
            p0_rdata_q   <= {BLOCK_LEN{1'b0}};
            p1_rdata_q   <= {BLOCK_LEN{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_addr_q    <= op_addr_d;
            op_wdata_q   <= op_wdata_d;
            op_is_read_q <= op_is_read_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    // Next-state, grant latching and read-data capture.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_addr_d    = op_addr_q;
        op_wdata_d   = op_wdata_q;
        op_is_read_d = op_is_read_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        case (state_q)
            IDLE: begin
                if (p0_req_s | p1_req_s) begin
                    state_d      = pick_p1_s ? BUSY1 : BUSY0;
                    last_grant_d = pick_p1_s;
                    op_addr_d    = pick_p1_s ? p1_address : p0_address;
                    op_wdata_d   = pick_p1_s ? p1_write_data : p0_write_data;
                    op_is_read_d = pick_p1_s ? p1_read_en : p0_read_en;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY0: begin
                if (sram_ready) begin
                    state_d = IDLE;
                    if (op_is_read_q) begin
                        p0_rdata_d = sram_read_data;
                    end else begin
                        p0_rdata_d = p0_rdata_q;
                    end
                end else begin
                    state_d = BUSY0;
                end
            end
            BUSY1: begin
                if (sram_ready) begin
                    state_d = IDLE;
                    if (op_is_read_q) begin
                        p1_rdata_d = sram_read_data;
                    end else begin
                        p1_rdata_d = p1_rdata_q;
                    end
                end else begin
                    state_d = BUSY1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant           = {state_q == BUSY1, state_q == BUSY0};
    assign sram_read_en    = (state_q != IDLE) & op_is_read_q;
    assign sram_write_en   = (state_q != IDLE) & ~op_is_read_q;
    assign sram_address    = op_addr_q;
    assign sram_write_data = op_wdata_q;

    // Ready drops for any waiting requester and rises only in its completion cycle.
    assign p0_ready     = ~p0_req_s | p0_done_s;
    assign p1_ready     = ~p1_req_s | p1_done_s;
    assign p0_read_data = p0_done_s ? sram_read_data : p0_rdata_q;
    assign p1_read_data = p1_done_s ? sram_read_data : p1_rdata_q;

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-port arbiter sharing the single SRAM controller between the data-side cache controller (port 0) and a second requester, the instruction-fetch miss path (port 1). It accepts level-held read/write requests from each port and grants the SRAM to one port at a time with round-robin fairness. It latches the granted address and write data and forwards `sram_ready` back as a per-port `ready` for pipeline freeze. It sits between the requesters and the SRAM controller; both requesters keep their existing request/ready protocol.

## Interface
- ADDR_LEN, 32, byte address width
- DATA_LEN, 32, write word width
- BLOCK_LEN, 64, SRAM read block width (two words)

- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset; synchronous and active-high, sampled on rising edge of clk
- p0_read_en, p1_read_en  in  1  port read request, held until port ready
- p0_write_en, p1_write_en  in  1  port write request, held until port ready
- p0_address, p1_address  in  ADDR_LEN  request address
- p0_write_data, p1_write_data  in  DATA_LEN  write word
- p0_read_data, p1_read_data  out  BLOCK_LEN  returned block
- p0_ready, p1_ready  out  1  port not stalled
- sram_read_en, sram_write_en  out  1  SRAM controller strobes
- sram_address  out  ADDR_LEN  latched granted address
- sram_write_data  out  DATA_LEN  latched granted write word
- sram_read_data  in  BLOCK_LEN  block from SRAM controller
- sram_ready  in  1  one-cycle SRAM completion pulse
- grant  out  2  one-hot owner: bit0 = port 0, bit1 = port 1, 00 = idle

## Operation
- Port i requests when `pi_read_en | pi_write_en`. If a port raises both, the read is served and the write is ignored.
- States: IDLE, BUSY0, BUSY1.
- IDLE:
  - With no request, stay in IDLE.
  - With one port requesting, go to BUSYi.
  - With both requesting, grant the port that is not `last_grant`.
  - On the grant edge, latch address, write data, and op (read/write) into `op_addr`, `op_wdata`, `op_is_read`. Set `last_grant` to i.
- BUSYi:
  - `sram_read_en = op_is_read`, `sram_write_en = ~op_is_read`. Strobes hold steady until `sram_ready`.
  - Latched address and write data drive the SRAM side. Requester input changes are ignored while BUSY.
  - When `sram_ready` is high, go to IDLE. On a read, capture `sram_read_data` into `pi_rdata_q`.
- Ready:
  - `pi_ready = ~(pi_read_en | pi_write_en) | (state == BUSYi & sram_ready)`. This is combinational.
  - A requesting port that is not granted, or whose transaction is in flight, sees ready low.
- Read data:
  - `pi_read_data = sram_read_data` in the completion cycle (BUSYi and `sram_ready`). Otherwise it is `pi_rdata_q`.
  - A completed read value stays valid until the next read completion on that port.
- `grant` is decoded from the state.
- An `sram_ready` pulse arriving in IDLE is ignored. No state change and no data capture.

## Timing
- Reset values: state IDLE, `last_grant` = port 1 (so port 0 wins the first tie), `op_*` = 0, `pi_rdata_q` = 0.
- Reset output values: sram strobes 0, `grant` 00, `pi_read_data` 0. `pi_ready` follows its equation, so it is 1 with no request.
- Latency: a request seen in IDLE at edge t drives the strobes from cycle t+1. The completion cycle is the first cycle with `sram_ready` high. The next grant edge is the edge after completion. There is a minimum one IDLE cycle between back-to-back transactions; this gap gives the SRAM controller its strobe-low cycle.
- A requester that advances on the completion edge may present a new request the very next cycle. That request is arbitrated normally in IDLE.
- rst asserted mid-transaction: on that edge return to IDLE and drop the strobes. No capture into `rdata_q` occurs, even if `sram_ready` is high in the same cycle. The SRAM controller shares `rst`.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1. No port waits more than one foreign transaction.

## Test plan
- Reset then idle: hold rst 2 cycles, no requests.
  - Required: strobes 0, `grant` 00, both ready 1, read data 0.
- Single read on port 0 at 0x0000_0404, SRAM returning 0xAAAA_BBBB_CCCC_DDDD after 5 cycles.
  - Required: `sram_read_en` high 5 cycles with `sram_address` 0x404.
  - Required: `p0_ready` low for 5 cycles, then high in the completion cycle with `p0_read_data` 0xAAAA_BBBB_CCCC_DDDD, held afterwards.
- Simultaneous port 0 write (0x100, 0x1234_5678) and port 1 read (0x200) from reset.
  - Required: port 0 is granted first and `sram_write_data` = 0x1234_5678.
  - Required: after completion there is one IDLE cycle, then port 1 is granted with `sram_address` 0x200. `p1_ready` stays low throughout.
- Both ports requesting continuously for 6 transactions.
  - Required: `grant` sequence 01,10,01,10,01,10 with one 00 cycle between each.
- Port 0 changes its address to 0x999 mid-transaction.
  - Required: `sram_address` stays at the latched value until completion.
- rst asserted in BUSY1 in the same cycle as `sram_ready`.
  - Required: next cycle is IDLE with strobes 0 and `p1_read_data` = previous held value (0 after reset).
